mfm_encoder: RTL
================

MFM_ENCODER -- requirements
Module: mfm_encoder

Interface
REQ-001 The block SHALL have parameter CELL_DIV, default 4, meaning clk cycles per MFM cell (legal 1..255).
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port wr_gate  input  1  write enable, streaming permitted while high.
REQ-005 The block SHALL have port data_in  input  8  byte to encode, MSB first.
REQ-006 The block SHALL have port data_mark  input  1  byte is an address mark, sampled with data_in.
REQ-007 The block SHALL have port data_valid  input  1  data_in/data_mark valid.
REQ-008 The block SHALL have port data_ready  output  1  one-byte holding buffer empty.
REQ-009 The block SHALL have port mfm_out  output  1  serial MFM cell stream to the downstream shifter.
REQ-010 The block SHALL have port cell_strobe  output  1  high on the first clk of each cell.
REQ-011 The block SHALL have port busy  output  1  high in state SHIFT.
REQ-012 The block SHALL have port underrun  output  1  sticky underrun flag.

Function
REQ-013 Bytes SHALL be accepted on a rising edge with data_valid & data_ready; the byte and its mark bit go to the holding buffer, and data_ready falls on the next cycle.
REQ-014 Each byte SHALL be encoded as 16 cells (clock, data) per bit, bit 7 first; data cell = bit; clock cell = 1 only when both the previous data bit and the current bit are 0.
REQ-015 With data_mark=1, the clock cell of bit 2 SHALL be forced to 0 (0xA1 gives 0x4489).
REQ-016 The previous-data-bit register SHALL carry across consecutive bytes, and SHALL be cleared to 0 on entry to IDLE.
REQ-017 The FSM SHALL have two states: IDLE (mfm_out=0, cell_strobe=0) and SHIFT.
REQ-018 IDLE->SHIFT SHALL occur when the buffer is full and wr_gate=1; the buffer moves to the shift register, data_ready rises, and cell 0 with cell_strobe appears on the next cycle.
REQ-019 Each cell SHALL be held for exactly CELL_DIV cycles; cell_strobe SHALL be high for one cycle per cell.
REQ-020 Byte boundary (last cycle of cell 15), decided in priority order:
  - wr_gate=0 -> IDLE; any buffered byte is retained.
  - buffer full -> load it and continue with no gap.
  - otherwise -> underrun (REQ-021).
REQ-021 On underrun, underrun SHALL be set to 1 and stay set until reset.
REQ-022 A wr_gate fall mid-byte SHALL NOT truncate the byte in progress.
REQ-023 A byte accepted on the boundary cycle itself SHALL NOT be used at that boundary.

Reset
REQ-024 Reset SHALL immediately force: state IDLE, mfm_out=0, cell_strobe=0, busy=0, underrun=0, data_ready=1, buffer empty, previous bit 0, counters 0.
REQ-025 Reset mid-byte SHALL abandon the byte with no further cells output.

Configuration
REQ-026 With macro MFM_GAP_FILL_EN defined, an underrun SHALL load 0x4E (mark=0) and keep streaming while wr_gate=1.
REQ-027 With MFM_GAP_FILL_EN undefined, an underrun SHALL enter IDLE, with mfm_out=0 from the next cycle.

Verification
REQ-028 Scenario 1: CELL_DIV=1, byte 0x00 from reset -> cells 0xAAAA, then IDLE; underrun=1 only if wr_gate is held high.
REQ-029 Scenario 2: 0xA1 with mark=1 -> 0x4489; 0xA1 with mark=0 -> 0x44A9.
REQ-030 Scenario 3: back-to-back 0xFF, 0x00 -> 0x5555 then 0x2AAA, with no gap cycle between them.
REQ-031 Scenario 4: 0x00 then starvation with wr_gate high. With MFM_GAP_FILL_EN -> 0xAAAA, 0x9254, 0x9254 (prev=0 before each fill byte), underrun=1. Without it -> 0xAAAA then mfm_out=0, busy=0, underrun=1.
REQ-032 Scenario 5: CELL_DIV=3 -> cell_strobe every 3 cycles, each cell held 3 cycles, 48 cycles per byte.
REQ-033 Scenario 6: CELL_DIV=4, reset asserted during cell 7 -> all outputs at reset values before the next clk edge; a byte accepted after release is encoded from a previous bit of 0.

Source files
------------

// File: rtl/mfm_encoder.sv
// mfm_encoder: byte-wide MFM (modified frequency modulation) cell encoder.
// A one-byte holding buffer feeds a 16-cell shift register; each cell is held
// for CELL_DIV clocks. Address marks drop the clock cell of bit 2 (0xA1 -> 0x4489).
// Optional build macro MFM_GAP_FILL_EN: on starvation, stream 0x4E gap bytes
// instead of stopping.
module mfm_encoder #(
    parameter int unsigned CELL_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_gate,
    input  logic [7:0] data_in,
    input  logic       data_mark,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       mfm_out,
    output logic       cell_strobe,
    output logic       busy,
    output logic       underrun
);

    // Handshake: a byte (data_in, data_mark) transfers on a rising clk edge where
    // data_valid && data_ready are both high; data_ready is high exactly while the
    // holding buffer is empty and does not depend on data_valid.

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CELL_DIV - 1);

    state_t      state_q, state_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        buf_mark_q, buf_mark_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  cell_q, cell_d;
    logic [7:0]  div_q, div_d;
    logic        prev_q, prev_d;
    logic        underrun_q, underrun_d;

    logic accept;
    logic cell_end;
    logic byte_end;
    logic starve;
    logic load_buf;
    logic load_fill;

    // Encode one byte into 16 cells, MSB first: (clock, data) per bit.
    function automatic logic [15:0] encode_byte(input logic [7:0] b, input logic mark,
                                                input logic prev);
        logic [15:0] w;
        logic        p;
        w = '0;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            w[2*i+1] = ~p & ~b[i];
            w[2*i]   = b[i];
            p        = b[i];
        end
        // Missing clock on bit 2 is what makes an address mark unique.
        if (mark) begin
            w[5] = 1'b0;
        end
        return w;
    endfunction

    assign accept   = data_valid & ~buf_full_q;
    assign cell_end = (div_q == DIV_LAST);
    assign byte_end = (state_q == SHIFT) && cell_end && (cell_q == 4'd15);
    // A byte accepted on the boundary edge is not yet in buf_full_q, so it cannot
    // rescue this boundary.
    assign starve   = byte_end & wr_gate & ~buf_full_q;
    assign load_buf = buf_full_q & wr_gate & ((state_q == IDLE) | byte_end);
`ifdef MFM_GAP_FILL_EN
    assign load_fill = starve;
`else
    assign load_fill = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: wr_gate is only honoured at byte boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_buf) state_d = SHIFT;
            SHIFT:   if (byte_end && !(load_buf || load_fill)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: holding buffer, shift register, cell/divider counters.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_mark_d = buf_mark_q;
        shift_d    = shift_q;
        cell_d     = cell_q;
        div_d      = div_q;
        prev_d     = prev_q;
        underrun_d = underrun_q | starve;

        if (load_buf) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_data_d = data_in;
            buf_mark_d = data_mark;
        end

        if (load_buf) begin
            shift_d = encode_byte(buf_data_q, buf_mark_q, prev_q);
            prev_d  = buf_data_q[0];
            cell_d  = 4'd0;
            div_d   = 8'd0;
        end else if (load_fill) begin
            shift_d = encode_byte(8'h4E, 1'b0, prev_q);
            prev_d  = 1'b0;
            cell_d  = 4'd0;
            div_d   = 8'd0;
        end else if (state_q == SHIFT) begin
            if (byte_end) begin
                // Leaving for IDLE: next stream starts from a clean previous bit.
                shift_d = '0;
                prev_d  = 1'b0;
                cell_d  = 4'd0;
                div_d   = 8'd0;
            end else if (cell_end) begin
                shift_d = {shift_q[14:0], 1'b0};
                cell_d  = cell_q + 4'd1;
                div_d   = 8'd0;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q <= 1'b0;
            buf_data_q <= 8'd0;
            buf_mark_q <= 1'b0;
            shift_q    <= 16'd0;
            cell_q     <= 4'd0;
            div_q      <= 8'd0;
            prev_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_mark_q <= buf_mark_d;
            shift_q    <= shift_d;
            cell_q     <= cell_d;
            div_q      <= div_d;
            prev_q     <= prev_d;
            underrun_q <= underrun_d;
        end
    end

    // Outputs decoded from state so reset silences them immediately.
    always_comb begin
        busy        = (state_q == SHIFT);
        mfm_out     = (state_q == SHIFT) & shift_q[15];
        cell_strobe = (state_q == SHIFT) & (div_q == 8'd0);
        data_ready  = ~buf_full_q;
        underrun    = underrun_q;
    end

endmodule
